// File: rtl/bsg_cache_pkg.sv
// Shared cache DMA types.
//   DECLARE_BSG_CACHE_DMA_PKT_S(addr_width) : declares bsg_cache_dma_pkt_s
//                                             {write_not_read, addr}
//   bsg_cache_dma_to_sram_state_e           : DMA-to-SRAM bridge FSM states
`ifndef BSG_CACHE_DMA_PKT_MACROS
`define BSG_CACHE_DMA_PKT_MACROS
`define DECLARE_BSG_CACHE_DMA_PKT_S(addr_width_mp) \
    typedef struct packed { \
        logic                     write_not_read; \
        logic [addr_width_mp-1:0] addr; \
    } bsg_cache_dma_pkt_s
`endif

package bsg_cache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } bsg_cache_dma_to_sram_state_e;

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear, wrapping to 0 after max_val_p.
//   clk_i, reset_n_i : clock, async active-low reset
//   clear_i          : restart from 0 (an up_i in the same cycle still counts)
//   up_i             : increment
//   count_o          : current count
module bsg_counter_clear_up #(
    parameter int max_val_p = 3,
    parameter int width_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               clear_i,
    input  logic               up_i,
    output logic [width_p-1:0] count_o
);

    localparam logic [width_p-1:0] max_lp = width_p'(max_val_p);

    logic [width_p-1:0] count_q, count_d, start;

    always_comb begin
        start   = clear_i ? '0 : count_q;
        count_d = start;
        if (up_i) count_d = (start == max_lp) ? '0 : start + width_p'(1);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) count_q <= '0;
        else            count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/bsg_cache_dma_to_sram.sv
// Bridges the cache DMA interface onto an external 1-port synchronous SRAM.
// A read packet streams one block out of the SRAM as fill words; a write
// packet stores one block of evict words into the SRAM.
//   clk_i, reset_n_i        : clock, async active-low reset
//   dma_pkt_i/_v_i/_yumi_o  : DMA request {write_not_read, byte addr}
//   dma_data_o/_v_o/_ready_i: fill words toward the cache
//   dma_data_i/_v_i/_yumi_o : evict words from the cache
//   mem_v_o/_w_o/_addr_o/_data_o, mem_data_i : SRAM port (read data
//                             arrives the cycle after the read and is held)
module bsg_cache_dma_to_sram
    import bsg_cache_pkg::*;
#(
    parameter int addr_width_p          = 32,
    parameter int data_width_p          = 32,
    parameter int block_size_in_words_p = 4,
    parameter int mem_els_p             = 128,
    localparam int lg_mem_els_lp        = $clog2(mem_els_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic [addr_width_p:0]    dma_pkt_i,
    input  logic                     dma_pkt_v_i,
    output logic                     dma_pkt_yumi_o,
    output logic [data_width_p-1:0]  dma_data_o,
    output logic                     dma_data_v_o,
    input  logic                     dma_data_ready_i,
    input  logic [data_width_p-1:0]  dma_data_i,
    input  logic                     dma_data_v_i,
    output logic                     dma_data_yumi_o,
    output logic                     mem_v_o,
    output logic                     mem_w_o,
    output logic [lg_mem_els_lp-1:0] mem_addr_o,
    output logic [data_width_p-1:0]  mem_data_o,
    input  logic [data_width_p-1:0]  mem_data_i
);

    `DECLARE_BSG_CACHE_DMA_PKT_S(addr_width_p);

    localparam int byte_off_lp = $clog2(data_width_p/8);
    localparam int lg_block_lp = $clog2(block_size_in_words_p);
    localparam int k_width_lp  = (lg_block_lp < 1) ? 1 : lg_block_lp;
    localparam logic [k_width_lp-1:0] k_last_lp = k_width_lp'(block_size_in_words_p-1);

    typedef logic [lg_mem_els_lp-1:0] maddr_t;

    bsg_cache_dma_pkt_s pkt;
    assign pkt = dma_pkt_i;

    // Byte address -> word address, aligned down to the block, modulo SRAM depth.
    maddr_t pkt_base;
    assign pkt_base = maddr_t'(((pkt.addr >> byte_off_lp) >> lg_block_lp) << lg_block_lp);

    bsg_cache_dma_to_sram_state_e state_q, state_d;
    maddr_t                       base_q, base_d;
    logic [k_width_lp-1:0]        k;
    logic                         k_clear, k_up;

    bsg_counter_clear_up #(
        .max_val_p(block_size_in_words_p-1),
        .width_p  (k_width_lp)
    ) u_word_cnt (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .clear_i  (k_clear),
        .up_i     (k_up),
        .count_o  (k)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        base_d          = base_q;
        k_clear         = 1'b0;
        k_up            = 1'b0;
        dma_pkt_yumi_o  = 1'b0;
        dma_data_o      = '0;
        dma_data_v_o    = 1'b0;
        dma_data_yumi_o = 1'b0;
        mem_v_o         = 1'b0;
        mem_w_o         = 1'b0;
        mem_addr_o      = '0;
        mem_data_o      = '0;

        unique case (state_q)
            IDLE: begin
                // Gated by reset so nothing leaks out while reset is held.
                if (reset_n_i && dma_pkt_v_i) begin
                    dma_pkt_yumi_o = 1'b1;
                    base_d         = pkt_base;
                    k_clear        = 1'b1;
                    if (pkt.write_not_read) begin
                        state_d = WRITE;
                    end else begin
                        // Prefetch word 0 so it is on mem_data_i when READ starts.
                        state_d    = READ;
                        mem_v_o    = 1'b1;
                        mem_addr_o = pkt_base;
                    end
                end
            end

            READ: begin
                dma_data_v_o = 1'b1;
                dma_data_o   = mem_data_i;
                // On a stall the SRAM is left idle so its output holds the word.
                if (dma_data_ready_i) begin
                    if (k == k_last_lp) begin
                        state_d = IDLE;
                    end else begin
                        k_up       = 1'b1;
                        mem_v_o    = 1'b1;
                        mem_addr_o = base_q + maddr_t'(k) + maddr_t'(1);
                    end
                end
            end

            WRITE: begin
                dma_data_yumi_o = dma_data_v_i;
                if (dma_data_v_i) begin
                    mem_v_o    = 1'b1;
                    mem_w_o    = 1'b1;
                    mem_addr_o = base_q + maddr_t'(k);
                    mem_data_o = dma_data_i;
                    k_up       = 1'b1;
                    if (k == k_last_lp) state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bsg_cache_dma_to_sram.sv
module tb_bsg_cache_dma_to_sram;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [32:0] dma_pkt;
    logic        pkt_v, pkt_yumi;
    logic [31:0] dma_data_o, dma_data_i;
    logic        data_v_o, ready, data_v_i, data_yumi;
    logic        mem_v, mem_w;
    logic [6:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    bsg_cache_dma_to_sram #(
        .addr_width_p(32), .data_width_p(32),
        .block_size_in_words_p(4), .mem_els_p(128)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .dma_pkt_i(dma_pkt), .dma_pkt_v_i(pkt_v), .dma_pkt_yumi_o(pkt_yumi),
        .dma_data_o(dma_data_o), .dma_data_v_o(data_v_o), .dma_data_ready_i(ready),
        .dma_data_i(dma_data_i), .dma_data_v_i(data_v_i), .dma_data_yumi_o(data_yumi),
        .mem_v_o(mem_v), .mem_w_o(mem_w), .mem_addr_o(mem_addr),
        .mem_data_o(mem_wdata), .mem_data_i(mem_rdata)
    );

    // External synchronous SRAM
    logic [31:0] sram [128];
    logic        sram_init;
    int          wr_cnt = 0;

    always @(posedge clk) begin
        if (sram_init) begin
            for (int i = 0; i < 128; i++) sram[i] <= 32'h5A5A0000 + i * 32'h01010101;
        end else if (mem_v) begin
            if (mem_w) sram[mem_addr] <= mem_wdata;
            else       mem_rdata      <= sram[mem_addr];
        end
    end

    always @(posedge clk) if (mem_v && mem_w) wr_cnt <= wr_cnt + 1;

    // Reference model: expected SRAM image
    logic [31:0] ref_mem [128];
    int n_pass = 0, n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    // word index = addr/4, aligned down to 4-word block, modulo 128 words
    function automatic logic [6:0] model_base(input logic [31:0] addr);
        return 7'(((addr / 32'd16) * 32'd4) % 32'd128);
    endfunction

    // Called with inputs settled some ns after a rising edge.
    task automatic do_write(input logic [31:0] addr, input logic [6:0] base, input logic [31:0] vpat);
        int n = 0, cyc = 0, wr0;
        logic [31:0] w;
        logic [6:0]  a;
        dma_pkt = {1'b1, addr}; pkt_v = 1'b1;
        #1;
        chk("wr_pkt_yumi", pkt_yumi, 1);
        chk("wr_accept_no_mem", mem_v, 0);
        @(posedge clk); #1;
        pkt_v = 1'b0; wr0 = wr_cnt;
        while (n < 4 && cyc < 64) begin
            logic v;
            v = (cyc < 32) ? vpat[cyc] : 1'b1;
            w = $urandom;
            data_v_i = v; dma_data_i = w;
            #1;
            chk("wr_yumi", data_yumi, v);
            chk("wr_mem_v", mem_v, v);
            chk("wr_no_pkt_yumi", pkt_yumi, 0);
            if (v) begin
                a = base + 7'(n);
                chk("wr_mem_w", mem_w, 1);
                chk("wr_addr", mem_addr, a);
                chk("wr_data", mem_wdata, w);
                ref_mem[a] = w;
                n++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        data_v_i = 1'b0;
        if (n < 4) chk("wr_timeout", n, 4);
        chk("wr_count", wr_cnt - wr0, 4);
        pkt_v = 1'b1; dma_pkt = {1'b0, addr};
        #1;
        chk("wr_back_idle", pkt_yumi, 1);
        pkt_v = 1'b0;
        @(posedge clk); #1;
    endtask

    // Packet valid is held high during the transfer to show it is not taken.
    task automatic do_read(input logic [31:0] addr, input logic [6:0] base, input logic [31:0] rpat);
        int n = 0, cyc = 0;
        dma_pkt = {1'b0, addr}; pkt_v = 1'b1;
        #1;
        chk("rd_pkt_yumi", pkt_yumi, 1);
        chk("rd_first_mem_v", mem_v, 1);
        chk("rd_first_mem_w", mem_w, 0);
        chk("rd_first_addr", mem_addr, base);
        @(posedge clk); #1;
        while (n < 4 && cyc < 64) begin
            logic r;
            r = (cyc < 32) ? rpat[cyc] : 1'b1;
            ready = r;
            #1;
            chk("rd_data_v", data_v_o, 1);
            chk("rd_data", dma_data_o, ref_mem[7'(base + 7'(n))]);
            chk("rd_no_pkt_yumi", pkt_yumi, 0);
            if (r && n < 3) begin
                chk("rd_mem_v", mem_v, 1);
                chk("rd_mem_w", mem_w, 0);
                chk("rd_addr", mem_addr, 7'(base + 7'(n + 1)));
            end else begin
                chk("rd_mem_idle", mem_v, 0);
            end
            @(posedge clk); #1;
            if (r) n++;
            cyc++;
        end
        pkt_v = 1'b0; ready = 1'b0;
        if (n < 4) chk("rd_timeout", n, 4);
        #1;
        chk("rd_done_v", data_v_o, 0);
        pkt_v = 1'b1;
        #1;
        chk("rd_back_idle", pkt_yumi, 1);
        pkt_v = 1'b0;
        @(posedge clk); #1;
    endtask

    typedef struct {
        bit          wnr;
        logic [31:0] addr;
        logic [31:0] pat;
        logic [6:0]  exp_base;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0040, 32'hFFFF_FFFF, 7'd16};
        vecs[1] = '{1'b0, 32'h0000_0040, 32'hFFFF_FFFF, 7'd16};
        vecs[2] = '{1'b0, 32'h0000_004C, 32'hFFFF_FFFF, 7'd16};
        vecs[3] = '{1'b0, 32'h0000_0040, 32'h0000_0059, 7'd16};   // ready 1,0,0,1,1,0,1
        vecs[4] = '{1'b1, 32'h0000_0100, 32'h0000_0065, 7'd64};   // v 1,0,1,0,0,1,1
        vecs[5] = '{1'b1, 32'h0000_01F0, 32'hFFFF_FFFF, 7'd124};
        vecs[6] = '{1'b0, 32'h0000_01F0, 32'hFFFF_FFFF, 7'd124};
        vecs[7] = '{1'b1, 32'h0000_0200, 32'hFFFF_FFFF, 7'd0};
        vecs[8] = '{1'b0, 32'h0000_0200, 32'h0000_0059, 7'd0};
        vecs[9] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7'd124};

        for (int i = 0; i < 128; i++) ref_mem[i] = 32'h5A5A0000 + i * 32'h01010101;

        // Reset with all inputs active: nothing may come out
        reset_n = 1'b0; sram_init = 1'b1;
        dma_pkt = {1'b0, 32'h40}; pkt_v = 1'b1;
        ready = 1'b1; data_v_i = 1'b1; dma_data_i = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        sram_init = 1'b0;
        chk("rst_pkt_yumi", pkt_yumi, 0);
        chk("rst_mem_v", mem_v, 0);
        chk("rst_mem_w", mem_w, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_data", mem_wdata, 0);
        chk("rst_data_v", data_v_o, 0);
        chk("rst_data_o", dma_data_o, 0);
        chk("rst_data_yumi", data_yumi, 0);
        pkt_v = 1'b0; ready = 1'b0; data_v_i = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Directed table
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].wnr) do_write(vecs[i].addr, vecs[i].exp_base, vecs[i].pat);
            else             do_read (vecs[i].addr, vecs[i].exp_base, vecs[i].pat);
        end

        // Reset in the middle of a write to block 16..19
        begin
            int wr0;
            logic [31:0] w;
            dma_pkt = {1'b1, 32'h40}; pkt_v = 1'b1;
            @(posedge clk); #1;
            pkt_v = 1'b0;
            for (int n = 0; n < 2; n++) begin
                w = $urandom;
                data_v_i = 1'b1; dma_data_i = w;
                ref_mem[16 + n] = w;
                @(posedge clk); #1;
            end
            data_v_i = 1'b1; dma_data_i = 32'hBAD0_BAD0; pkt_v = 1'b1;
            #1;
            chk("mid_pre_rst_mem_v", mem_v, 1);
            reset_n = 1'b0;
            #1;
            chk("mid_rst_mem_v", mem_v, 0);
            chk("mid_rst_data_yumi", data_yumi, 0);
            chk("mid_rst_pkt_yumi", pkt_yumi, 0);
            chk("mid_rst_mem_addr", mem_addr, 0);
            wr0 = wr_cnt;
            @(posedge clk); @(posedge clk); #1;
            chk("mid_rst_no_writes", wr_cnt - wr0, 0);
            data_v_i = 1'b0; pkt_v = 1'b0;
            reset_n = 1'b1;
            // Accept on the very first edge after release; words 18,19 unchanged
            do_read(32'h40, 7'd16, 32'hFFFF_FFFF);
        end

        // Random traffic against the model
        for (int t = 0; t < 40; t++) begin
            logic [31:0] addr, pat;
            addr = $urandom;
            pat  = $urandom | $urandom;
            if ($urandom_range(1, 0) == 1) do_write(addr, model_base(addr), pat);
            else                            do_read (addr, model_base(addr), pat);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
